sdram_rd_fifo_feeder: RTL and testbench

Write-side feeder for the SDRAM-to-stream async FIFO. It runs in the WClk domain and fetches a programmed number of 16-bit words from SDRAM as fixed-length read bursts. Each returned beat is written into the FIFO; the FIFO's Wen drives the RAM write enable directly. A new burst is requested only while the FIFO reports not-full. Data arriving while Full is asserted is dropped and flagged.

---
 rtl/sdram_fifo_pkg.sv | 16 +
 rtl/sdram_rd_fifo_feeder.sv | 145 ++++++++++++++
 tb/tb_sdram_rd_fifo_feeder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_fifo_pkg.sv
// Shared definitions for the SDRAM read path feeding the stream async FIFO.
// Burst length is shared with the SDRAM controller so both sides agree on beat counts.
package sdram_fifo_pkg;

  localparam int unsigned BURST_LEN_DFLT = 8;
  localparam int unsigned ADDR_W_DFLT    = 24;
  localparam int unsigned DATA_W_DFLT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } feeder_state_e;

endpackage : sdram_fifo_pkg

// File: rtl/sdram_rd_fifo_feeder.sv
// Write-side feeder: fetches a programmed word count from SDRAM in fixed bursts
// and pushes each returned beat into the async FIFO, dropping beats while Full.
module sdram_rd_fifo_feeder
  import sdram_fifo_pkg::*;
#(
  parameter int unsigned Addr_Width = ADDR_W_DFLT,
  parameter int unsigned Data_Width = DATA_W_DFLT,
  parameter int unsigned Burst_Len  = BURST_LEN_DFLT,
  parameter int unsigned Cnt_Width  = 16
) (
  input  logic                  WClk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [Addr_Width-1:0] Start_Addr,
  input  logic [Cnt_Width-1:0]  Xfer_Words,
  output logic                  Rd_Req,
  output logic [Addr_Width-1:0] Rd_Addr,
  input  logic                  Rd_Ack,
  input  logic                  Rd_Valid,
  input  logic [Data_Width-1:0] Rd_Data,
  input  logic                  Fifo_Full,
  output logic                  Fifo_Wen,
  output logic [Data_Width-1:0] Fifo_Wdata,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overflow
);

  localparam int unsigned BEAT_W = (Burst_Len > 1) ? $clog2(Burst_Len) : 1;
  localparam logic [BEAT_W-1:0]     BEAT_LAST  = BEAT_W'(Burst_Len - 1);
  localparam logic [Cnt_Width-1:0]  BURST_CNT  = Cnt_Width'(Burst_Len);
  localparam logic [Cnt_Width-1:0]  LOW_MASK   = Cnt_Width'(Burst_Len - 1);
  localparam logic [Addr_Width-1:0] BURST_ADDR = Addr_Width'(Burst_Len);

  feeder_state_e         state_q, state_d;
  logic                  rd_req_q, rd_req_d;
  logic [Addr_Width-1:0] rd_addr_q, rd_addr_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [Cnt_Width-1:0]  remaining_q, remaining_d;
  logic                  fifo_wen_q, fifo_wen_d;
  logic [Data_Width-1:0] fifo_wdata_q, fifo_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic [Cnt_Width-1:0]  start_words_c;
  logic [Cnt_Width-1:0]  rem_after_burst_c;

  // Partial bursts are never fetched: the sub-burst remainder is discarded.
  assign start_words_c     = Xfer_Words & ~LOW_MASK;
  assign rem_after_burst_c = remaining_q - BURST_CNT;

  always_ff @(posedge WClk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_IDLE;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      beat_q       <= '0;
      remaining_q  <= '0;
      fifo_wen_q   <= 1'b0;
      fifo_wdata_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      beat_q       <= beat_d;
      remaining_q  <= remaining_d;
      fifo_wen_q   <= fifo_wen_d;
      fifo_wdata_q <= fifo_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    beat_d       = beat_q;
    remaining_d  = remaining_q;
    fifo_wen_d   = 1'b0;
    fifo_wdata_d = fifo_wdata_q;
    overflow_d   = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          rd_addr_d   = Start_Addr;
          remaining_d = start_words_c;
          overflow_d  = 1'b0;
          state_d     = (start_words_c == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // A raised request is held until acked, even if the FIFO fills meanwhile.
        if (rd_req_q) begin
          if (Rd_Ack) begin
            rd_req_d  = 1'b0;
            rd_addr_d = rd_addr_q + BURST_ADDR;
            beat_d    = '0;
            state_d   = ST_WAIT_DATA;
          end
        end else begin
          rd_req_d = ~Fifo_Full;
        end
      end
      ST_WAIT_DATA: begin
        if (Rd_Valid) begin
          fifo_wdata_d = Rd_Data;
          fifo_wen_d   = ~Fifo_Full;
          if (Fifo_Full) begin
            overflow_d = 1'b1;
          end
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            remaining_d = rem_after_burst_c;
            state_d     = (rem_after_burst_c == '0) ? ST_DONE : ST_REQ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign Rd_Req     = rd_req_q;
  assign Rd_Addr    = rd_addr_q;
  assign Fifo_Wen   = fifo_wen_q;
  assign Fifo_Wdata = fifo_wdata_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Overflow   = overflow_q;

endmodule : sdram_rd_fifo_feeder

// File: tb/tb_sdram_rd_fifo_feeder.sv
// Directed bench for sdram_rd_fifo_feeder: drives the SDRAM handshake and
// FIFO Full by hand and compares outputs against hand-computed values.
module tb_sdram_rd_fifo_feeder;

  logic        WClk;
  logic        Rst_n;
  logic        Start;
  logic [23:0] Start_Addr;
  logic [15:0] Xfer_Words;
  logic        Rd_Req;
  logic [23:0] Rd_Addr;
  logic        Rd_Ack;
  logic        Rd_Valid;
  logic [15:0] Rd_Data;
  logic        Fifo_Full;
  logic        Fifo_Wen;
  logic [15:0] Fifo_Wdata;
  logic        Busy;
  logic        Done;
  logic        Overflow;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  sdram_rd_fifo_feeder #(
    .Addr_Width (24),
    .Data_Width (16),
    .Burst_Len  (8),
    .Cnt_Width  (16)
  ) dut (
    .WClk       (WClk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .Start_Addr (Start_Addr),
    .Xfer_Words (Xfer_Words),
    .Rd_Req     (Rd_Req),
    .Rd_Addr    (Rd_Addr),
    .Rd_Ack     (Rd_Ack),
    .Rd_Valid   (Rd_Valid),
    .Rd_Data    (Rd_Data),
    .Fifo_Full  (Fifo_Full),
    .Fifo_Wen   (Fifo_Wen),
    .Fifo_Wdata (Fifo_Wdata),
    .Busy       (Busy),
    .Done       (Done),
    .Overflow   (Overflow)
  );

  initial WClk = 1'b0;
  always #5 WClk = ~WClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge WClk);
    #1;
  endtask

  task automatic start_xfer(input logic [23:0] addr, input logic [15:0] words);
    Start      = 1'b1;
    Start_Addr = addr;
    Xfer_Words = words;
    tick();
    Start = 1'b0;
  endtask

  // Waits for a request at exp_addr, acks after 2 cycles, then returns n_beats
  // beats; beats with index in [full_lo, full_hi] arrive while the FIFO is full.
  task automatic serve_burst(input logic [23:0] exp_addr, input int full_lo,
                             input int full_hi, input int n_beats);
    logic [15:0] d;
    int          waited;
    waited = 0;
    while (!Rd_Req && waited < 40) begin
      tick();
      waited++;
    end
    if (!Rd_Req) begin
      chk("req_timeout", 32'(Rd_Req), 32'd1);
      return;
    end
    chk("req_addr", 32'(Rd_Addr), 32'(exp_addr));
    tick();
    chk("req_hold", 32'(Rd_Req), 32'd1);
    tick();
    Rd_Ack = 1'b1;
    tick();
    Rd_Ack = 1'b0;
    chk("req_drop", 32'(Rd_Req), 32'd0);
    for (int b = 0; b < n_beats; b++) begin
      d         = exp_addr[15:0] ^ 16'hC300 ^ 16'(b * 16'h0101);
      Fifo_Full = (b >= full_lo) && (b <= full_hi);
      Rd_Valid  = 1'b1;
      Rd_Data   = d;
      tick();
      chk("wen", 32'(Fifo_Wen), (b >= full_lo && b <= full_hi) ? 32'd0 : 32'd1);
      if (Fifo_Wen) begin
        wr_cnt++;
        chk("wdata", 32'(Fifo_Wdata), 32'(d));
      end
    end
    Rd_Valid  = 1'b0;
    Fifo_Full = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n      = 1'b0;
    Start      = 1'b0;
    Start_Addr = '0;
    Xfer_Words = '0;
    Rd_Ack     = 1'b0;
    Rd_Valid   = 1'b0;
    Rd_Data    = '0;
    Fifo_Full  = 1'b0;
    #3;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_req", 32'(Rd_Req), 32'd0);
    chk("rst_addr", 32'(Rd_Addr), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_ovf", 32'(Overflow), 32'd0);
    tick();
    Rst_n = 1'b1;
    tick();

    // 32 words from 0x100: four bursts, no backpressure.
    start_xfer(24'h000100, 16'd32);
    chk("t1_busy", 32'(Busy), 32'd1);
    chk("t1_req_c1", 32'(Rd_Req), 32'd0);
    serve_burst(24'h000100, -1, -1, 8);
    serve_burst(24'h000108, -1, -1, 8);
    serve_burst(24'h000110, -1, -1, 8);
    serve_burst(24'h000118, -1, -1, 8);
    chk("t1_done", 32'(Done), 32'd1);
    chk("t1_busy_done", 32'(Busy), 32'd1);
    chk("t1_ovf", 32'(Overflow), 32'd0);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd32);
    tick();
    chk("t1_done_clr", 32'(Done), 32'd0);
    chk("t1_idle", 32'(Busy), 32'd0);
    chk("t1_no_req", 32'(Rd_Req), 32'd0);

    // Stray beats while idle must not write.
    Rd_Valid = 1'b1;
    Rd_Data  = 16'hDEAD;
    tick();
    Rd_Valid = 1'b0;
    chk("idle_valid_wen", 32'(Fifo_Wen), 32'd0);

    // FIFO full on REQ entry; stray Ack and Start are ignored meanwhile.
    Fifo_Full = 1'b1;
    start_xfer(24'h000600, 16'd8);
    Rd_Ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      Start      = (i == 3);
      Start_Addr = 24'h000777;
      tick();
      chk("t2_req_blocked", 32'(Rd_Req), 32'd0);
    end
    Start     = 1'b0;
    Rd_Ack    = 1'b0;
    Fifo_Full = 1'b0;
    chk("t2_addr_kept", 32'(Rd_Addr), 32'h000600);
    wr_cnt = 0;
    serve_burst(24'h000600, -1, -1, 8);
    chk("t2_done", 32'(Done), 32'd1);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd8);
    tick();

    // Full during beats 3-4 of the first burst drops them and sets Overflow.
    wr_cnt = 0;
    start_xfer(24'h000200, 16'd16);
    serve_burst(24'h000200, 2, 3, 8);
    chk("t3_ovf_set", 32'(Overflow), 32'd1);
    serve_burst(24'h000208, -1, -1, 8);
    chk("t3_done", 32'(Done), 32'd1);
    chk("t3_ovf_hold", 32'(Overflow), 32'd1);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd14);
    tick();
    chk("t3_ovf_idle", 32'(Overflow), 32'd1);

    // Address wrap; the new Start clears Overflow.
    start_xfer(24'hFFFFF8, 16'd16);
    chk("t4_ovf_clr", 32'(Overflow), 32'd0);
    serve_burst(24'hFFFFF8, -1, -1, 8);
    serve_burst(24'h000000, -1, -1, 8);
    chk("t4_done", 32'(Done), 32'd1);
    tick();

    // Sub-burst count: straight to DONE; Start during DONE is ignored.
    start_xfer(24'h000300, 16'd5);
    chk("t5_done", 32'(Done), 32'd1);
    chk("t5_busy", 32'(Busy), 32'd1);
    chk("t5_no_req", 32'(Rd_Req), 32'd0);
    start_xfer(24'hABCDEF, 16'd8);
    chk("t5_done_clr", 32'(Done), 32'd0);
    chk("t5_idle", 32'(Busy), 32'd0);
    chk("t5_addr", 32'(Rd_Addr), 32'h000300);
    chk("t5_no_req2", 32'(Rd_Req), 32'd0);
    tick();

    // Async reset during beat 4 of the second burst.
    start_xfer(24'h000400, 16'd16);
    serve_burst(24'h000400, 0, 0, 8);
    serve_burst(24'h000408, -1, -1, 3);
    chk("t6_pre_wen", 32'(Fifo_Wen), 32'd1);
    chk("t6_pre_ovf", 32'(Overflow), 32'd1);
    Rd_Valid = 1'b1;
    Rd_Data  = 16'h1234;
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(Busy), 32'd0);
    chk("t6_rst_wen", 32'(Fifo_Wen), 32'd0);
    chk("t6_rst_wdata", 32'(Fifo_Wdata), 32'd0);
    chk("t6_rst_addr", 32'(Rd_Addr), 32'd0);
    chk("t6_rst_ovf", 32'(Overflow), 32'd0);
    chk("t6_rst_req", 32'(Rd_Req), 32'd0);
    chk("t6_rst_done", 32'(Done), 32'd0);
    Rd_Valid = 1'b0;
    tick();
    tick();
    Rst_n = 1'b1;
    tick();
    wr_cnt = 0;
    start_xfer(24'h000500, 16'd8);
    serve_burst(24'h000500, -1, -1, 8);
    chk("t6_done", 32'(Done), 32'd1);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd8);
    tick();
    chk("t6_idle", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sdram_rd_fifo_feeder
